fxp_seq_divider: RTL and testbench



---
 rtl/fxp_seq_divider.sv | 221 ++++++++++++++++++++++
 tb/tb_fxp_seq_divider.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fxp_seq_divider.sv
// Iterative fixed-point divider: quotient = (dividend << FRAC) / divisor.
// Optional two's-complement mode: define FXP_SEQ_DIVIDER_SIGNED_EN.
module fxp_seq_divider #(
  parameter int WIDTH = 17,
  parameter int FRAC  = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int NQ = WIDTH + FRAC;
  localparam int CW = $clog2(NQ + 1);
  localparam logic [CW-1:0] LAST = CW'(NQ - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
  localparam logic [1:0] S_FIX  = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [NQ-1:0]    num_q, num_d;
  logic [NQ-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] src_rem;
  logic [NQ-1:0]    src_num;
  logic [WIDTH-1:0] src_dvs;
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH-1:0] st_rem;
  logic [NQ-1:0]    st_num;
  logic [NQ-1:0]    st_quo;

`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic [NQ-1:0]    lim;
  logic             fix_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign dvd_mag = mag(dividend);
  assign dvs_mag = mag(divisor);
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

  // One restoring step; the accept edge runs the first step on fresh operands.
  always_comb begin
    src_rem = rem_q;
    src_num = num_q;
    src_dvs = dvs_q;
    if (state_q == S_IDLE) begin
      src_rem = '0;
      src_num = {dvd_mag, {FRAC{1'b0}}};
      src_dvs = dvs_mag;
    end
    sh     = {src_rem, src_num[NQ-1]};
    ge     = (sh >= {1'b0, src_dvs});
    st_rem = ge ? (sh[WIDTH-1:0] - src_dvs) : sh[WIDTH-1:0];
    st_num = {src_num[NQ-2:0], 1'b0};
    st_quo = (state_q == S_IDLE) ? NQ'(ge) : {quo_q[NQ-2:0], ge};
  end

`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
  // Signed range check on the unsigned quotient magnitude.
  always_comb begin
    lim     = NQ'({1'b0, {(WIDTH-1){1'b1}}}) + NQ'(sq_q);
    fix_ovf = (quo_q > lim);
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    num_d   = num_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
    sq_d    = sq_q;
    sr_d    = sr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvs_d = dvs_mag;
`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
          sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_d  = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            state_d = S_DONE;
            remo_d  = '0;
            ovf_d   = 1'b1;
            dbz_d   = 1'b1;
`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
            quot_d  = dividend[WIDTH-1] ?
                      {1'b1, {(WIDTH-1){1'b0}}} :
                      {1'b0, {(WIDTH-1){1'b1}}};
`else
            quot_d  = '1;
`endif
          end else begin
            state_d = S_BUSY;
            cnt_d   = CW'(1);
            rem_d   = st_rem;
            num_d   = st_num;
            quo_d   = st_quo;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        rem_d = st_rem;
        num_d = st_num;
        quo_d = st_quo;
        if (cnt_q == LAST) begin
`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
          ovf_d   = |st_quo[NQ-1:WIDTH];
          quot_d  = ovf_d ? '1 : st_quo[WIDTH-1:0];
          remo_d  = st_rem;
          dbz_d   = 1'b0;
`endif
        end
      end
`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
      S_FIX: begin
        state_d = S_DONE;
        ovf_d   = fix_ovf;
        dbz_d   = 1'b0;
        if (fix_ovf)
          quot_d = sq_q ? {1'b1, {(WIDTH-1){1'b0}}} :
                          {1'b0, {(WIDTH-1){1'b1}}};
        else
          quot_d = sq_q ? (~quo_q[WIDTH-1:0] + 1'b1) :
                          quo_q[WIDTH-1:0];
        remo_d  = sr_q ? (~rem_q + 1'b1) : rem_q;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
`ifdef FXP_SEQ_DIVIDER_SIGNED_EN
      sq_q    <= sq_d;
      sr_q    <= sr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Directed bench for fxp_seq_divider, default unsigned build.
// Expected quotients are (dividend*2^17)/divisor computed by hand.
module tb_fxp_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] dividend;
  logic [16:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] quotient;
  logic [16:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  fxp_seq_divider #(.WIDTH(17), .FRAC(17)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [16:0] a,
                        input logic [16:0] b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume(input string t);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({t, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({t, "_ir_rise"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string t,
                     input logic [16:0] a, b,
                     input int lat,
                     input logic [16:0] eq, er,
                     input logic eo, ez);
    int n;
    accept(a, b);
    wait_done(n);
    check({t, "_lat"}, 32'(n), 32'(lat));
    check({t, "_q"}, 32'(quotient), 32'(eq));
    check({t, "_r"}, 32'(remainder), 32'(er));
    check({t, "_ovf"}, 32'(overflow), 32'(eo));
    check({t, "_dbz"}, 32'(div_by_zero), 32'(ez));
    check({t, "_ir"}, 32'(in_ready), 32'd0);
    consume(t);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("d1_2", 17'd1, 17'd2, 34, 17'd65536, 17'd0, 1'b0, 1'b0);
    run("d1_3", 17'd1, 17'd3, 34, 17'd43690, 17'd2, 1'b0, 1'b0);
    run("d3_2", 17'd3, 17'd2, 34, 17'h1FFFF, 17'd0, 1'b1, 1'b0);
    run("d5_0", 17'd5, 17'd0, 1, 17'h1FFFF, 17'd0, 1'b1, 1'b1);
    run("d7_8", 17'd7, 17'd8, 34, 17'd114688, 17'd0, 1'b0, 1'b0);
    run("dmax", 17'h1FFFF, 17'h1FFFF, 34, 17'h1FFFF, 17'd0, 1'b1, 1'b0);
    run("d1_m", 17'd1, 17'h1FFFF, 34, 17'd1, 17'd1, 1'b0, 1'b0);

    accept(17'd1, 17'd3);
    wait_done(n);
    check("bp_lat", 32'(n), 32'd34);
    in_valid = 1'b1;
    dividend = 17'd9;
    divisor  = 17'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_ir", 32'(in_ready), 32'd0);
      check("bp_q", 32'(quotient), 32'd43690);
      check("bp_r", 32'(remainder), 32'd2);
    end
    in_valid = 1'b0;
    consume("bp");
    run("bp_next", 17'd1, 17'd2, 34, 17'd65536, 17'd0, 1'b0, 1'b0);

    out_ready = 1'b1;
    accept(17'd1, 17'd3);
    repeat (9) @(posedge clk);
    #1;
    check("mid_ov", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_ir", 32'(in_ready), 32'd1);
    check("mr_ov", 32'(out_valid), 32'd0);
    check("mr_q", 32'(quotient), 32'd0);
    check("mr_r", 32'(remainder), 32'd0);
    check("mr_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("mr_next", 17'd1, 17'd3, 34, 17'd43690, 17'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
